// File: rtl/tinyriscv_pkg.sv
// Shared types and constants for the tinyriscv front end.
package tinyriscv_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } pc_state_e;

    localparam int PcIncr32 = 4;
    localparam int PcIncr16 = 2;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch request interface between the PC generator (master) and the fetch unit (slave).
interface pc_gen_if #(
    parameter int AddrWidth = 32
);

    logic                 fetch_valid_o;
    logic                 fetch_ready_i;
    logic [AddrWidth-1:0] pc_o;
    logic [AddrWidth-1:0] pc_next_o;
    logic                 compressed_i;

    modport master (
        output fetch_valid_o,
        output pc_o,
        output pc_next_o,
        input  fetch_ready_i,
        input  compressed_i
    );

    modport slave (
        input  fetch_valid_o,
        input  pc_o,
        input  pc_next_o,
        output fetch_ready_i,
        output compressed_i
    );

endinterface

// File: rtl/pc_redirect_arb.sv
// Fixed-priority redirect selector: source 0 wins over all others.
module pc_redirect_arb #(
    parameter int AddrWidth   = 32,
    parameter int NumRedirect = 3,
    parameter bit CExt        = 1'b1
) (
    input  logic [NumRedirect-1:0]           redirect_valid,
    input  logic [NumRedirect*AddrWidth-1:0] redirect_addr,
    output logic                             sel_valid,
    output logic [AddrWidth-1:0]             sel_addr,
    output logic                             sel_misaligned
);

    // Walk from the lowest-priority source upward so the lowest valid index is the last writer.
    always_comb begin
        sel_valid = 1'b0;
        sel_addr  = '0;
        for (int k = NumRedirect - 1; k >= 0; k--) begin
            if (redirect_valid[k]) begin
                sel_valid = 1'b1;
                sel_addr  = redirect_addr[k*AddrWidth +: AddrWidth];
            end
        end
    end

    // Byte-odd targets are never legal; halfword targets are legal only with compressed support.
    assign sel_misaligned = sel_valid && (sel_addr[0] || (!CExt && sel_addr[1]));

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: boot delay, prioritised redirects, 2/4-byte advance and debug halt.
module pc_gen
    import tinyriscv_pkg::*;
#(
    parameter int                 AddrWidth   = 32,
    parameter logic [AddrWidth-1:0] ResetAddr = '0,
    parameter int                 NumRedirect = 3,
    parameter bit                 CExt        = 1'b1,
    parameter int                 BootDelay   = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             jtag_reset_i,
    input  logic [NumRedirect-1:0]           redirect_valid_i,
    input  logic [NumRedirect*AddrWidth-1:0] redirect_addr_i,
    input  logic                             hold_i,
    input  logic                             halt_req_i,
    input  logic                             resume_req_i,
    pc_gen_if.master                         fetch,
    output logic                             halted_o,
    output logic                             misaligned_o,
    output logic [AddrWidth-1:0]             misaligned_addr_o
);

    localparam logic [3:0] BootCntLast = 4'(BootDelay - 1);

    pc_state_e            state;
    logic [AddrWidth-1:0] pc_q;
    logic [AddrWidth-1:0] pc_incr;
    logic [AddrWidth-1:0] pc_next;
    logic [3:0]           boot_cnt;
    logic                 halt_pending;
    logic                 fetch_valid_q;

    logic                 sel_valid;
    logic [AddrWidth-1:0] sel_addr;
    logic                 sel_misaligned;
    logic                 redirect_ok;
    logic                 advance;

    pc_redirect_arb #(
        .AddrWidth   (AddrWidth),
        .NumRedirect (NumRedirect),
        .CExt        (CExt)
    ) u_arb (
        .redirect_valid (redirect_valid_i),
        .redirect_addr  (redirect_addr_i),
        .sel_valid      (sel_valid),
        .sel_addr       (sel_addr),
        .sel_misaligned (sel_misaligned)
    );

    assign pc_incr     = (CExt && fetch.compressed_i) ? AddrWidth'(PcIncr16) : AddrWidth'(PcIncr32);
    assign pc_next     = pc_q + pc_incr;
    assign redirect_ok = sel_valid && !sel_misaligned;
    assign advance     = fetch_valid_q && fetch.fetch_ready_i && !hold_i;

    assign fetch.pc_o          = pc_q;
    assign fetch.pc_next_o     = pc_next;
    assign fetch.fetch_valid_o = fetch_valid_q;

    // PC register, misalignment reporting and the BOOT/RUN/HALTED state machine.
    always_ff @(posedge clk_i) begin
        if (rst_i || jtag_reset_i) begin
            state             <= BOOT;
            pc_q              <= ResetAddr;
            boot_cnt          <= '0;
            halt_pending      <= 1'b0;
            fetch_valid_q     <= 1'b0;
            halted_o          <= 1'b0;
            misaligned_o      <= 1'b0;
            misaligned_addr_o <= '0;
        end else begin
            misaligned_o <= sel_valid && sel_misaligned;
            if (sel_valid && sel_misaligned) begin
                misaligned_addr_o <= sel_addr;
            end

            if (redirect_ok) begin
                pc_q <= sel_addr;
            end else if (advance) begin
                pc_q <= pc_next;
            end

            case (state)
                BOOT: begin
                    if (boot_cnt == BootCntLast) begin
                        halt_pending <= 1'b0;
                        if (halt_pending || halt_req_i) begin
                            state    <= HALTED;
                            halted_o <= 1'b1;
                        end else begin
                            state         <= RUN;
                            fetch_valid_q <= 1'b1;
                        end
                    end else begin
                        boot_cnt <= boot_cnt + 4'd1;
                        if (halt_req_i) begin
                            halt_pending <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (halt_req_i) begin
                        state         <= HALTED;
                        fetch_valid_q <= 1'b0;
                        halted_o      <= 1'b1;
                    end
                end
                HALTED: begin
                    if (resume_req_i && !halt_req_i) begin
                        state         <= RUN;
                        fetch_valid_q <= 1'b1;
                        halted_o      <= 1'b0;
                    end
                end
                default: begin
                    state         <= BOOT;
                    boot_cnt      <= '0;
                    fetch_valid_q <= 1'b0;
                    halted_o      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen: one DUT with compressed support, one without.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        jtag_reset;
    logic [2:0]  redirect_valid;
    logic [95:0] redirect_addr;
    logic        hold;
    logic        halt_req;
    logic        resume_req;
    logic        fetch_ready;
    logic        compressed;

    logic        a_halted, a_mis, b_halted, b_mis;
    logic [31:0] a_mis_addr, b_mis_addr;

    int checks = 0;
    int errors = 0;

    pc_gen_if #(.AddrWidth(32)) if_a ();
    pc_gen_if #(.AddrWidth(32)) if_b ();

    assign if_a.fetch_ready_i = fetch_ready;
    assign if_a.compressed_i  = compressed;
    assign if_b.fetch_ready_i = fetch_ready;
    assign if_b.compressed_i  = compressed;

    pc_gen #(
        .AddrWidth(32), .ResetAddr(32'h8000_0000), .NumRedirect(3), .CExt(1'b1), .BootDelay(2)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .jtag_reset_i(jtag_reset),
        .redirect_valid_i(redirect_valid), .redirect_addr_i(redirect_addr),
        .hold_i(hold), .halt_req_i(halt_req), .resume_req_i(resume_req),
        .fetch(if_a.master),
        .halted_o(a_halted), .misaligned_o(a_mis), .misaligned_addr_o(a_mis_addr)
    );

    pc_gen #(
        .AddrWidth(32), .ResetAddr(32'h0000_0000), .NumRedirect(3), .CExt(1'b0), .BootDelay(2)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .jtag_reset_i(jtag_reset),
        .redirect_valid_i(redirect_valid), .redirect_addr_i(redirect_addr),
        .hold_i(hold), .halt_req_i(halt_req), .resume_req_i(resume_req),
        .fetch(if_b.master),
        .halted_o(b_halted), .misaligned_o(b_mis), .misaligned_addr_o(b_mis_addr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; jtag_reset = 1'b0; redirect_valid = '0; redirect_addr = '0;
        hold = 1'b0; halt_req = 1'b0; resume_req = 1'b0; fetch_ready = 1'b1; compressed = 1'b0;
        tick(); tick();
        checks++; if (if_a.pc_o !== 32'h8000_0000) begin errors++; $display("[TB] FAIL reset_pc got %h expected %h", if_a.pc_o, 32'h8000_0000); end
        checks++; if (if_a.fetch_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b expected 0", if_a.fetch_valid_o); end
        checks++; if (a_halted !== 1'b0 || a_mis !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags got %b%b expected 00", a_halted, a_mis); end
        checks++; if (a_mis_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_mis_addr got %h expected 0", a_mis_addr); end
        checks++; if (if_b.pc_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc_b got %h expected 0", if_b.pc_o); end
        rst = 1'b0;
        tick();
        checks++; if (if_a.fetch_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL boot_cycle1_valid got %b expected 0", if_a.fetch_valid_o); end
        tick();
        checks++; if (if_a.fetch_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL boot_cycle2_valid got %b expected 1", if_a.fetch_valid_o); end
        checks++; if (if_a.pc_o !== 32'h8000_0000) begin errors++; $display("[TB] FAIL first_fetch_pc got %h expected %h", if_a.pc_o, 32'h8000_0000); end
        tick();
        checks++; if (if_a.pc_o !== 32'h8000_0004) begin errors++; $display("[TB] FAIL seq_pc1 got %h expected %h", if_a.pc_o, 32'h8000_0004); end
        tick();
        checks++; if (if_a.pc_o !== 32'h8000_0008) begin errors++; $display("[TB] FAIL seq_pc2 got %h expected %h", if_a.pc_o, 32'h8000_0008); end
        checks++; if (if_a.pc_next_o !== 32'h8000_000C) begin errors++; $display("[TB] FAIL seq_pc_next got %h expected %h", if_a.pc_next_o, 32'h8000_000C); end
        checks++; if (if_b.pc_o !== 32'h0000_0008) begin errors++; $display("[TB] FAIL seq_pc_b got %h expected 8", if_b.pc_o); end
    endtask

    task automatic test_compressed();
        redirect_valid = 3'b001; redirect_addr[31:0] = 32'h0000_0100;
        tick();
        redirect_valid = 3'b000;
        checks++; if (if_a.pc_o !== 32'h100) begin errors++; $display("[TB] FAIL redirect_100 got %h expected 100", if_a.pc_o); end
        compressed = 1'b1;
        #1;
        checks++; if (if_a.pc_next_o !== 32'h102) begin errors++; $display("[TB] FAIL pc_next_c got %h expected 102", if_a.pc_next_o); end
        checks++; if (if_b.pc_next_o !== 32'h104) begin errors++; $display("[TB] FAIL pc_next_noc got %h expected 104", if_b.pc_next_o); end
        tick();
        compressed = 1'b0;
        checks++; if (if_a.pc_o !== 32'h102) begin errors++; $display("[TB] FAIL adv_c got %h expected 102", if_a.pc_o); end
        checks++; if (if_b.pc_o !== 32'h104) begin errors++; $display("[TB] FAIL adv_noc got %h expected 104", if_b.pc_o); end
        fetch_ready = 1'b0;
        tick();
        checks++; if (if_a.pc_o !== 32'h102 || if_a.fetch_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL not_ready_hold got pc %h valid %b expected 102 1", if_a.pc_o, if_a.fetch_valid_o); end
        fetch_ready = 1'b1; hold = 1'b1;
        tick();
        checks++; if (if_a.pc_o !== 32'h102) begin errors++; $display("[TB] FAIL hold_with_ready got %h expected 102", if_a.pc_o); end
    endtask

    task automatic test_priority();
        redirect_valid = 3'b110; redirect_addr[63:32] = 32'h200; redirect_addr[95:64] = 32'h300;
        tick();
        checks++; if (if_a.pc_o !== 32'h200) begin errors++; $display("[TB] FAIL prio_src1 got %h expected 200", if_a.pc_o); end
        redirect_valid = 3'b111; redirect_addr[31:0] = 32'h240;
        tick();
        checks++; if (if_a.pc_o !== 32'h240) begin errors++; $display("[TB] FAIL prio_src0 got %h expected 240", if_a.pc_o); end
        redirect_valid = 3'b000; hold = 1'b0;
    endtask

    task automatic test_misaligned();
        fetch_ready = 1'b0;
        redirect_valid = 3'b001; redirect_addr[31:0] = 32'h201;
        tick();
        redirect_valid = 3'b000;
        checks++; if (if_a.pc_o !== 32'h240) begin errors++; $display("[TB] FAIL mis_pc_kept got %h expected 240", if_a.pc_o); end
        checks++; if (a_mis !== 1'b1 || a_mis_addr !== 32'h201) begin errors++; $display("[TB] FAIL mis_pulse got %b %h expected 1 201", a_mis, a_mis_addr); end
        tick();
        checks++; if (a_mis !== 1'b0 || a_mis_addr !== 32'h201) begin errors++; $display("[TB] FAIL mis_one_cycle got %b %h expected 0 201", a_mis, a_mis_addr); end
        redirect_valid = 3'b001; redirect_addr[31:0] = 32'h202;
        tick();
        redirect_valid = 3'b000;
        checks++; if (if_a.pc_o !== 32'h202 || a_mis !== 1'b0) begin errors++; $display("[TB] FAIL half_ok_c got %h %b expected 202 0", if_a.pc_o, a_mis); end
        checks++; if (if_b.pc_o !== 32'h240 || b_mis !== 1'b1 || b_mis_addr !== 32'h202) begin errors++; $display("[TB] FAIL half_rej_noc got %h %b %h expected 240 1 202", if_b.pc_o, b_mis, b_mis_addr); end
        fetch_ready = 1'b1;
    endtask

    task automatic test_halt();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        checks++; if (a_halted !== 1'b1 || if_a.fetch_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL halt_enter got %b %b expected 1 0", a_halted, if_a.fetch_valid_o); end
        checks++; if (if_a.pc_o !== 32'h206) begin errors++; $display("[TB] FAIL halt_adv got %h expected 206", if_a.pc_o); end
        redirect_valid = 3'b001; redirect_addr[31:0] = 32'h400;
        tick();
        redirect_valid = 3'b000;
        checks++; if (if_a.pc_o !== 32'h400 || a_halted !== 1'b1) begin errors++; $display("[TB] FAIL halt_redirect got %h %b expected 400 1", if_a.pc_o, a_halted); end
        tick();
        checks++; if (if_a.pc_o !== 32'h400) begin errors++; $display("[TB] FAIL halt_no_adv got %h expected 400", if_a.pc_o); end
        resume_req = 1'b1; halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        checks++; if (a_halted !== 1'b1) begin errors++; $display("[TB] FAIL resume_with_halt got %b expected 1", a_halted); end
        tick();
        resume_req = 1'b0;
        checks++; if (a_halted !== 1'b0 || if_a.fetch_valid_o !== 1'b1 || if_a.pc_o !== 32'h400) begin errors++; $display("[TB] FAIL resume got %b %b %h expected 0 1 400", a_halted, if_a.fetch_valid_o, if_a.pc_o); end
        tick();
        checks++; if (if_a.pc_o !== 32'h404) begin errors++; $display("[TB] FAIL resume_adv got %h expected 404", if_a.pc_o); end
    endtask

    task automatic test_wrap();
        redirect_valid = 3'b001; redirect_addr[31:0] = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 3'b000;
        checks++; if (if_a.pc_next_o !== 32'h0) begin errors++; $display("[TB] FAIL wrap_next got %h expected 0", if_a.pc_next_o); end
        tick();
        checks++; if (if_a.pc_o !== 32'h0) begin errors++; $display("[TB] FAIL wrap_pc got %h expected 0", if_a.pc_o); end
    endtask

    task automatic test_jtag_reset();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        checks++; if (a_halted !== 1'b1) begin errors++; $display("[TB] FAIL pre_jtag_halt got %b expected 1", a_halted); end
        jtag_reset = 1'b1;
        tick();
        jtag_reset = 1'b0;
        checks++; if (if_a.pc_o !== 32'h8000_0000 || a_halted !== 1'b0 || if_a.fetch_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL jtag_reset got %h %b %b expected 80000000 0 0", if_a.pc_o, a_halted, if_a.fetch_valid_o); end
    endtask

    task automatic test_boot_halt();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        checks++; if (if_a.fetch_valid_o !== 1'b0 || a_halted !== 1'b0) begin errors++; $display("[TB] FAIL boot_halt_pending got %b %b expected 0 0", if_a.fetch_valid_o, a_halted); end
        tick();
        checks++; if (if_a.fetch_valid_o !== 1'b0 || a_halted !== 1'b1) begin errors++; $display("[TB] FAIL boot_exit_halt got %b %b expected 0 1", if_a.fetch_valid_o, a_halted); end
        tick();
        checks++; if (if_a.fetch_valid_o !== 1'b0 || if_a.pc_o !== 32'h8000_0000) begin errors++; $display("[TB] FAIL boot_halt_stay got %b %h expected 0 80000000", if_a.fetch_valid_o, if_a.pc_o); end
        resume_req = 1'b1;
        tick();
        resume_req = 1'b0;
        checks++; if (if_a.fetch_valid_o !== 1'b1 || a_halted !== 1'b0) begin errors++; $display("[TB] FAIL boot_halt_resume got %b %b expected 1 0", if_a.fetch_valid_o, a_halted); end
    endtask

    initial begin
        test_reset();
        test_compressed();
        test_priority();
        test_misaligned();
        test_halt();
        test_wrap();
        test_jtag_reset();
        test_boot_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised successor to the single-source PC register: generates the fetch PC for the tinyriscv front end.
- Adds prioritised multi-source redirects, 2/4-byte increment (C extension), a post-reset boot delay, debug halt/resume, a fetch valid/ready handshake and misaligned-target detection.
- Sits between the control/trap/debug units (redirect sources) and the instruction fetch interface.

Parameters:
- AddrWidth, 32, PC width in bits.
- ResetAddr, 32'h0000_0000, PC value after reset or JTAG reset (AddrWidth bits).
- NumRedirect, 3, number of redirect sources; index 0 is highest priority.
- CExt, 1, 1 = 16-bit alignment and 2-byte increment allowed; 0 = 32-bit only.
- BootDelay, 2, cycles in BOOT before the first fetch request (range 1..15).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- jtag_reset_i  in  1  soft reset; same effect as rst_i
- redirect_valid_i  in  NumRedirect  per-source redirect request
- redirect_addr_i  in  NumRedirect*AddrWidth  targets; source k occupies bits [k*AddrWidth +: AddrWidth]
- hold_i  in  1  pipeline stall; blocks sequential advance only
- compressed_i  in  1  instruction at pc_o is 16-bit (ignored when CExt=0)
- halt_req_i  in  1  debug halt request
- resume_req_i  in  1  debug resume request
- fetch_ready_i  in  1  fetch unit accepts pc_o
- fetch_valid_o  out  1  pc_o is a valid fetch request
- pc_o  out  AddrWidth  current fetch PC
- pc_next_o  out  AddrWidth  sequential successor of pc_o (combinational)
- halted_o  out  1  core is in debug halt
- misaligned_o  out  1  one-cycle pulse: rejected misaligned redirect
- misaligned_addr_o  out  AddrWidth  last rejected target

Behaviour:
- Reset (rst_i or jtag_reset_i high at clk edge):
  - state=BOOT, pc_o=ResetAddr, boot counter=0.
  - fetch_valid_o=0, halted_o=0, misaligned_o=0, misaligned_addr_o=0.
  - Overrides every other input and applies in any state.
- pc_next_o = pc_o + (CExt && compressed_i ? 2 : 4), truncated to AddrWidth; wraps modulo 2^AddrWidth with no flag.
- States (tinyriscv_pkg::pc_state_e):
  - BOOT: fetch_valid_o=0; counter increments each cycle; when counter==BootDelay-1, next state is RUN. First fetch_valid_o=1 appears exactly BootDelay cycles after reset deasserts.
  - RUN: fetch_valid_o=1.
  - HALTED: fetch_valid_o=0, halted_o=1.
- Redirect selection: lowest index k with redirect_valid_i[k]=1 wins; other sources are ignored that cycle.
- Misaligned target: addr[0]=1, or addr[1:0]!=0 when CExt=0.
  - PC is not updated.
  - misaligned_o=1 in the following cycle only; misaligned_addr_o latches the target.
- PC update priority in RUN, evaluated per cycle:
  1. Aligned redirect: pc_o <= target next cycle, regardless of hold_i or fetch_ready_i. An unaccepted in-flight request is squashed.
  2. Sequential advance: fetch_valid_o && fetch_ready_i && !hold_i gives pc_o <= pc_next_o.
  3. Otherwise pc_o holds, and fetch_valid_o stays high (valid is never withdrawn without a redirect).
- Redirect in BOOT: pc_o updates, and the boot countdown continues.
- Redirect in HALTED: pc_o updates (debugger writes DPC); state remains HALTED.
- Halt:
  - halt_req_i in RUN: state=HALTED next cycle.
  - If a handshake completes in that same cycle, the advance is still applied.
  - Halt together with a redirect: both the redirect and the halt are applied.
  - halt_req_i in BOOT is held pending and taken on BOOT exit, so RUN is never entered.
- Resume: resume_req_i in HALTED gives RUN next cycle. Resume and halt_req both high in HALTED: stay HALTED.
- Boundary case: hold_i=1 with fetch_ready_i=1 gives no advance.

Decomposition:
- Add to tinyriscv_pkg:
  - pc_state_e {BOOT, RUN, HALTED}
  - PcIncr32=4, PcIncr16=2
- One sub-module, pc_redirect_arb: combinational fixed-priority selector over NumRedirect sources. Outputs sel_valid, sel_addr and sel_misaligned (evaluated according to CExt).
- The FSM, boot counter and PC register stay in pc_gen.

Test Plan:
- Reset release, BootDelay=2, ResetAddr=0x8000_0000, fetch_ready_i=1 -> fetch_valid_o rises on the 2nd cycle after reset; pc_o then 0x8000_0000, 0x8000_0004, 0x8000_0008.
- compressed_i=1 at pc 0x100 -> next pc 0x102. With CExt=0 the same stimulus -> 0x104.
- redirect_valid_i=3'b110, sources 1/2 = 0x200/0x300, with hold_i=1 -> pc_o=0x200 next cycle.
- Redirect to 0x201 -> pc_o unchanged; misaligned_o pulses for 1 cycle; misaligned_addr_o=0x201.
- halt_req_i in RUN -> halted_o=1 and fetch_valid_o=0 next cycle; redirect to 0x400 while halted -> pc_o=0x400, still halted; resume_req_i -> fetch of 0x400.
- pc=0xFFFF_FFFC advancing -> 0x0000_0000. jtag_reset_i mid-HALTED -> BOOT with pc_o=ResetAddr and halted_o=0.
